// File: rtl/dsp_array_pkg.sv
// Shared types and defaults for the row-sequential limb multiplier array.
package dsp_array_pkg;

  typedef enum logic {
    MULT   = 1'b0,
    SQUARE = 1'b1
  } mul_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  // Sideband that travels alongside each beat through the multiplier pipe.
  typedef struct packed {
    logic      valid;
    logic      last;
    mul_mode_e mode;
  } pipe_ctl_t;

  localparam int DEF_NUM_ELEMENTS = 62;
  localparam int DEF_BIT_LEN      = 18;

  // Product width including the extra bit needed for off-diagonal doubling.
  function automatic int pp_len(input int bit_len);
    return 2 * bit_len + 1;
  endfunction

endpackage

// File: rtl/dsp_mul_pipe.sv
// Unsigned BIT_LEN x BIT_LEN multiplier with MUL_STAGES clock-enabled registers.
module dsp_mul_pipe #(
  parameter int BIT_LEN    = 18,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce_i,
  input  logic [BIT_LEN-1:0]   a_i,
  input  logic [BIT_LEN-1:0]   b_i,
  output logic [2*BIT_LEN-1:0] p_o
);

  localparam int PROD_W = 2 * BIT_LEN;

  logic [MUL_STAGES-1:0][PROD_W-1:0] p_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (ce_i) begin
      p_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
      for (int s = 1; s < MUL_STAGES; s++) begin
        p_q[s] <= p_q[s-1];
      end
    end
  end

  assign p_o = p_q[MUL_STAGES-1];

endmodule

// File: rtl/dsp_tri_mul_seq.sv
// Row-sequential partial-product generator: LANES rows of A[i]*B[j] per beat, MULT or SQUARE.
module dsp_tri_mul_seq
  import dsp_array_pkg::*;
#(
  parameter int  NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int  BIT_LEN      = DEF_BIT_LEN,
  parameter int  LANES        = 2,
  parameter int  MUL_STAGES   = 2,
  localparam int PP_LEN       = pp_len(BIT_LEN),
  localparam int ROW_W        = $clog2(NUM_ELEMENTS)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  mul_mode_e                                    in_mode,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]         in_a,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]         in_b,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ROW_W-1:0]                             out_row,
  output logic                                         out_last,
  output logic [LANES-1:0][NUM_ELEMENTS-1:0][PP_LEN-1:0] out_pp
);

  localparam int              PROD_W   = 2 * BIT_LEN;
  localparam int              LAST_S   = MUL_STAGES - 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ELEMENTS - LANES);
  localparam logic [ROW_W-1:0] ROW_STEP = ROW_W'(LANES);

  if (NUM_ELEMENTS % LANES != 0) begin : g_bad_lanes
    $error("NUM_ELEMENTS must be a multiple of LANES");
  end
  if (MUL_STAGES < 1) begin : g_bad_stages
    $error("MUL_STAGES must be at least 1");
  end

  fsm_state_e                          state_q, state_d;
  logic [ROW_W-1:0]                    ctr_q, ctr_d;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] a_q, b_q;
  mul_mode_e                           mode_q;
  logic                                stall, accept, issue, issue_last;

  assign stall  = out_valid && !out_ready;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      IDLE:    if (accept) begin state_d = RUN; ctr_d = '0; end
      RUN:     if (issue) begin
                 ctr_d = ctr_q + ROW_STEP;
                 if (issue_last) state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE) && !stall;
    issue      = (state_q == RUN) && !stall;
    issue_last = issue && (ctr_q == LAST_ROW);
  end

  // NOTE: operand registers carry no reset; nothing reads them until an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= in_a;
      b_q    <= (in_mode == SQUARE) ? in_a : in_b;
      mode_q <= in_mode;
    end
  end

  logic [LANES-1:0][BIT_LEN-1:0]                    lane_a;
  logic [LANES-1:0][NUM_ELEMENTS-1:0][PROD_W-1:0]   prod;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_a[k] = a_q[ctr_q + ROW_W'(k)];
    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_col
      dsp_mul_pipe #(
        .BIT_LEN    (BIT_LEN),
        .MUL_STAGES (MUL_STAGES)
      ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .ce_i  (!stall),
        .a_i   (lane_a[k]),
        .b_i   (b_q[j]),
        .p_o   (prod[k][j])
      );
    end
  end

  pipe_ctl_t [MUL_STAGES-1:0]            ctl_q;
  logic      [MUL_STAGES-1:0][ROW_W-1:0] row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      row_q <= '0;
    end else if (!stall) begin
      ctl_q[0] <= '{valid: issue, last: issue_last, mode: mode_q};
      row_q[0] <= ctr_q;
      for (int s = 1; s < MUL_STAGES; s++) begin
        ctl_q[s] <= ctl_q[s-1];
        row_q[s] <= row_q[s-1];
      end
    end
  end

  // Triangle masking and doubling on the way into the output register.
  logic [LANES-1:0][NUM_ELEMENTS-1:0][PP_LEN-1:0] pp_d;
  logic [PP_LEN-1:0]                              term;
  int                                             row_i;

  always_comb begin
    pp_d  = '0;
    term  = '0;
    row_i = 0;
    for (int k = 0; k < LANES; k++) begin
      row_i = int'(row_q[LAST_S]) + k;
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        term = PP_LEN'(prod[k][j]);
        if (ctl_q[LAST_S].mode == SQUARE) begin
          if (j < row_i)      term = '0;
          else if (j > row_i) term = term << 1;
        end
        pp_d[k][j] = term;
      end
    end
  end

  logic                                           out_valid_q, out_last_q;
  logic [ROW_W-1:0]                               out_row_q;
  logic [LANES-1:0][NUM_ELEMENTS-1:0][PP_LEN-1:0] out_pp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_pp_q    <= '0;
    end else if (!stall) begin
      out_valid_q <= ctl_q[LAST_S].valid;
      out_last_q  <= ctl_q[LAST_S].valid && ctl_q[LAST_S].last;
      out_row_q   <= row_q[LAST_S];
      out_pp_q    <= pp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_row   = out_row_q;
  assign out_pp    = out_pp_q;

endmodule

// File: tb/tb_dsp_tri_mul_seq.sv
// Directed bench for dsp_tri_mul_seq at NUM_ELEMENTS=4, LANES=2, MUL_STAGES=2.
module tb_dsp_tri_mul_seq;
  import dsp_array_pkg::*;

  localparam int NE  = 4;
  localparam int BL  = 18;
  localparam int LN  = 2;
  localparam int MS  = 2;
  localparam int PPL = 2 * BL + 1;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b1;
  logic                           in_valid = 1'b0;
  logic                           in_ready;
  mul_mode_e                      in_mode = MULT;
  logic [NE-1:0][BL-1:0]          in_a = '0;
  logic [NE-1:0][BL-1:0]          in_b = '0;
  logic                           out_valid;
  logic                           out_ready = 1'b1;
  logic [1:0]                     out_row;
  logic                           out_last;
  logic [LN-1:0][NE-1:0][PPL-1:0] out_pp;

  dsp_tri_mul_seq #(
    .NUM_ELEMENTS (NE),
    .BIT_LEN      (BL),
    .LANES        (LN),
    .MUL_STAGES   (MS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .out_pp    (out_pp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]                    cyc;
    logic [1:0]                     row;
    logic                           last;
    logic [LN-1:0][NE-1:0][PPL-1:0] pp;
  } beat_t;

  beat_t got_q[$];

  // Beats are logged at the negedge before the edge that completes their handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back('{cyc: 32'(cyc), row: out_row, last: out_last, pp: out_pp});
  end

  typedef logic [1:0][1:0][3:0][63:0] op_tab_t;  // [beat][lane][column]

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][63:0] row4(input longint unsigned c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic start_op(input mul_mode_e m, input logic [NE-1:0][BL-1:0] a, b, output int acc);
    @(negedge clk);
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    acc      = -1;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("accept_timeout", 64'(in_ready), 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int t = 0; t < 60 && got_q.size() < n; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({tag, ".count"}, 64'(got_q.size()), 64'(n));
  endtask

  task automatic wait_valid(input string tag);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, ".seen"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_op(input string tag, input op_tab_t e, input int acc, input int base,
                          input bit timed);
    for (int b = 0; b < 2; b++) begin
      beat_t g;
      g = (got_q.size() > base + b) ? got_q[base+b] : '0;
      check($sformatf("%s.b%0d.row", tag, b), 64'(g.row), 64'(2 * b));
      check($sformatf("%s.b%0d.last", tag, b), 64'(g.last), 64'(b == 1));
      if (timed) check($sformatf("%s.b%0d.cycle", tag, b), 64'(g.cyc), 64'(acc + MS + 1 + b));
      for (int k = 0; k < LN; k++)
        for (int j = 0; j < NE; j++)
          check($sformatf("%s.b%0d.r%0d.c%0d", tag, b, 2 * b + k, j), 64'(g.pp[k][j]), e[b][k][j]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_tab_t               t_mult, t_sq, t_max;
    logic [NE-1:0][BL-1:0] va, vmax;
    longint unsigned       dg, od;
    int                    acc, acc2;

    t_mult[0][0] = row4(1, 2, 3, 4);
    t_mult[0][1] = row4(2, 4, 6, 8);
    t_mult[1][0] = row4(3, 6, 9, 12);
    t_mult[1][1] = row4(4, 8, 12, 16);

    t_sq[0][0] = row4(1, 4, 6, 8);
    t_sq[0][1] = row4(0, 4, 12, 16);
    t_sq[1][0] = row4(0, 0, 9, 24);
    t_sq[1][1] = row4(0, 0, 0, 16);

    dg = 64'h0_000F_FFF8_0001;  // (2^18-1)^2
    od = 64'h0_001F_FFF0_0002;  // 2*(2^18-1)^2
    t_max[0][0] = row4(dg, od, od, od);
    t_max[0][1] = row4(0, dg, od, od);
    t_max[1][0] = row4(0, 0, dg, od);
    t_max[1][1] = row4(0, 0, 0, dg);

    va   = {18'd4, 18'd3, 18'd2, 18'd1};
    vmax = '1;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_last", 64'(out_last), 64'd0);
    check("rst.out_row", 64'(out_row), 64'd0);
    check("rst.out_pp_any", 64'(|out_pp), 64'd0);
    rst_n = 1'b1;

    start_op(MULT, va, va, acc);
    in_valid = 1'b0;
    wait_beats("mult", 2);
    check_op("mult", t_mult, acc, 0, 1'b1);
    got_q.delete();

    start_op(SQUARE, va, '1, acc);
    in_valid = 1'b0;
    wait_beats("square", 2);
    check_op("square", t_sq, acc, 0, 1'b1);
    got_q.delete();

    start_op(SQUARE, vmax, vmax, acc);
    in_valid = 1'b0;
    wait_beats("maxlimb", 2);
    check_op("maxlimb", t_max, acc, 0, 1'b1);
    got_q.delete();

    // Hold off the second beat for five cycles.
    start_op(SQUARE, va, '1, acc);
    in_valid = 1'b0;
    wait_valid("stall");
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("stall.c%0d.valid", s), 64'(out_valid), 64'd1);
      check($sformatf("stall.c%0d.row", s), 64'(out_row), 64'd2);
      check($sformatf("stall.c%0d.last", s), 64'(out_last), 64'd1);
      for (int k = 0; k < LN; k++)
        for (int j = 0; j < NE; j++)
          check($sformatf("stall.c%0d.r%0d.c%0d", s, 2 + k, j), 64'(out_pp[k][j]), t_sq[1][k][j]);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_beats("stall", 2);
    check_op("stall", t_sq, acc, 0, 1'b0);
    got_q.delete();

    // in_valid stays high across both accepts.
    start_op(MULT, va, va, acc);
    start_op(SQUARE, va, '1, acc2);
    in_valid = 1'b0;
    check("b2b.accept_gap", 64'(acc2 - acc), 64'd3);
    wait_beats("b2b", 4);
    check_op("b2b.op1", t_mult, acc, 0, 1'b1);
    check_op("b2b.op2", t_sq, acc2, 2, 1'b1);
    got_q.delete();

    // Reset while beat 1 of 2 is presented.
    start_op(MULT, va, va, acc);
    in_valid = 1'b0;
    wait_valid("rstmid");
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", 64'(out_valid), 64'd0);
    check("rstmid.in_ready", 64'(in_ready), 64'd1);
    check("rstmid.out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    repeat (10) @(posedge clk);
    check("rstmid.no_stale", 64'(got_q.size()), 64'd0);

    start_op(MULT, va, va, acc);
    in_valid = 1'b0;
    wait_beats("post_rst", 2);
    check_op("post_rst", t_mult, acc, 0, 1'b1);
    got_q.delete();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
